// File: rtl/fib_decoder.sv
// fib_decoder: sequential inverse of the 16-bit Fibonacci stream generator.
// A request latches a 16-bit word. The block then regenerates the sequence
// S(0)=1, S(1)=2, S(2)=3, ... one term per cycle and reports the step index k
// at which the generator would have produced that word, or reports "not found".
//
// Handshake: a request is accepted on any rising edge where the block is in
// IDLE and start=1. start is ignored in every other state and is not queued.
// The result is presented with a one-cycle done pulse. found/index are held
// from that pulse until the next accepted start, where they clear to 0.
module fib_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [4:0]  index,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] tgt_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        found_q;
  logic [4:0]  index_q;

  // Next term kept at 17 bits so a carry out of 16 bits can never alias
  // onto a small target and produce a false match.
  logic [16:0] sum;
  logic [16:0] tgt_ext;

  assign sum     = {1'b0, a_q} + {1'b0, b_q};
  assign tgt_ext = {1'b0, tgt_q};

  // Control FSM with registered outputs; reset has priority over start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= 16'd0;
      b_q     <= 16'd1;
      tgt_q   <= 16'd0;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      index_q <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            tgt_q   <= value;
            a_q     <= 16'd0;
            b_q     <= 16'd1;
            cnt_q   <= 5'd0;
            found_q <= 1'b0;
            index_q <= 5'd0;
            busy_q  <= 1'b1;
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          if (sum == tgt_ext) begin
            found_q <= 1'b1;
            index_q <= cnt_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (sum[16] || (sum > tgt_ext)) begin
            // Sequence is strictly increasing: once past the target it
            // can never match, so stop here.
            found_q <= 1'b0;
            index_q <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            a_q   <= b_q;
            b_q   <= sum[15:0];
            cnt_q <= cnt_q + 5'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign index     = index_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fib_decoder.sv
// Testbench for fib_decoder: directed steps plus randomized words, checked
// against a table of generator terms built with plain arithmetic.
module tb_fib_decoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic        found;
  logic [4:0]  index;
  logic [1:0]  dbg_state;

  int checks;
  int failures;
  int seq_tab[0:23];

  fib_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .value     (value),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .index     (index),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: first term S(j) >= v decides the outcome; done follows E(j+1).
  task automatic model(input int v, output bit exp_f, output int exp_k, output int exp_lat);
    exp_f = 1'b0; exp_k = 0; exp_lat = 24;
    for (int j = 0; j < 24; j++) begin
      if (seq_tab[j] >= v) begin
        exp_f   = (seq_tab[j] == v);
        exp_k   = exp_f ? j : 0;
        exp_lat = j + 1;
        break;
      end
    end
  endtask

  // Issue one request from IDLE and check the whole response.
  task automatic do_req(input logic [15:0] v, input string tag,
                        output logic obs_f, output logic [4:0] obs_k);
    bit ef; int ek; int el; int n;
    model(int'(v), ef, ek, el);
    @(negedge clk);
    start = 1'b1;
    value = v;
    tick();
    start = 1'b0;
    check({tag, "_busy_e0"}, busy, 1);
    check({tag, "_found_clr"}, found, 0);
    check({tag, "_index_clr"}, index, 0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, el);
    check({tag, "_found"}, found, ef);
    check({tag, "_index"}, index, ek);
    check({tag, "_busy_done"}, busy, 0);
    obs_f = found;
    obs_k = index;
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_found_hold"}, found, ef);
    check({tag, "_index_hold"}, index, ek);
  endtask

  initial begin
    logic       of;
    logic [4:0] ok;
    int         n;
    int         saw;
    int         gp, gc, gt;
    logic [15:0] rv;

    checks = 0;
    failures = 0;
    seq_tab[0] = 1;
    seq_tab[1] = 2;
    for (int j = 2; j < 24; j++) seq_tab[j] = seq_tab[j-1] + seq_tab[j-2];

    rst = 1'b0; start = 1'b0; value = 16'd0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_index", index, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Directed cases
    do_req(16'd1,     "v1",     of, ok);
    do_req(16'd46368, "v46368", of, ok);
    do_req(16'd13,    "v13",    of, ok);
    do_req(16'd4,     "v4",     of, ok);
    do_req(16'd0,     "v0",     of, ok);
    do_req(16'd65535, "v65535", of, ok);

    // start during SEARCH is ignored
    @(negedge clk);
    start = 1'b1; value = 16'd46368;
    tick();
    start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    start = 1'b1; value = 16'd2;
    @(negedge clk);
    start = 1'b0;
    n = 4;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("ign_latency", n, 23);
    check("ign_found", found, 1);
    check("ign_index", index, 22);
    tick();
    do_req(16'd2, "v2_after", of, ok);

    // Reset during SEARCH drops the request
    @(negedge clk);
    start = 1'b1; value = 16'd46368;
    tick();
    start = 1'b0;
    repeat (9) tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_found", found, 0);
    check("mid_rst_index", index, 0);
    @(negedge clk);
    rst = 1'b1;
    saw = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1) saw++;
    end
    check("mid_rst_no_done", saw, 0);

    // Sweep against a bench-side generator stepped by enables
    gp = 1; gc = 1;
    for (int k = 0; k < 23; k++) begin
      do_req(gc[15:0], "sweep", of, ok);
      check("sweep_found", of, 1);
      check("sweep_index", ok, k);
      gt = gp + gc; gp = gc; gc = gt;
    end

    // Randomized words, half of them near a sequence term
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) rv = 16'($urandom_range(0, 65535));
      else rv = 16'(seq_tab[$urandom_range(0, 22)] + $urandom_range(0, 2) - 1);
      do_req(rv, "rand", of, ok);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
